// File: rtl/frame_store_pkg.sv
// frame_store_pkg: entry layout constants and pointer helpers shared by the frame store FIFO.
// Optional drop counter is enabled with FRAME_STORE_DROP_CNT_EN (see frame_store_fifo).
package frame_store_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int EOD_FLAG_W = 1;

  function automatic int eod_bit_idx(input int data_w);
    return data_w;
  endfunction

  function automatic int entry_width(input int data_w);
    return data_w + EOD_FLAG_W;
  endfunction

  // Pointers carry one wrap bit, so the difference is taken modulo 2**(addr_w+1)
  function automatic int unsigned ptr_occupancy(input int unsigned wr_ptr,
                                                input int unsigned rd_ptr,
                                                input int unsigned addr_w);
    int unsigned mask;
    mask = (32'd1 << (addr_w + 32'd1)) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/frame_store_ram.sv
// frame_store_ram: simple dual-port RAM, synchronous write and registered read, block-RAM friendly.
module frame_store_ram
  import frame_store_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [entry_width(DATA_W)-1:0] wr_data,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [entry_width(DATA_W)-1:0] rd_data
);

  localparam int ENTRY_W = entry_width(DATA_W);
  localparam int DEPTH   = 1 << ADDR_W;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [ENTRY_W-1:0] rd_data_r;

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/frame_store_fifo.sv
// frame_store_fifo: store-and-forward frame FIFO exposing only committed frames; aborts and overflows drop whole frames.
// Define FRAME_STORE_DROP_CNT_EN to implement the saturating drop_cnt counter (otherwise drop_cnt reads 0).
module frame_store_fifo
  import frame_store_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int AFULL_LVL = (1 << ADDR_W) - 64
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_en,
  input  logic                  wr_eod,
  input  logic                  wr_abort,
  output logic                  full_flag,
  output logic                  afull_flag,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_eod,
  output logic                  rd_valid,
  output logic                  frame_avail,
  output logic [ADDR_W:0]       frame_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ENTRY_W = entry_width(DATA_W);
  localparam int EOD_BIT = eod_bit_idx(DATA_W);
  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]     wr_ptr_r, cm_ptr_r, rd_ptr_r, frame_cnt_r;
  logic [ADDR_W:0]     wr_ptr_s, cm_ptr_s, rd_ptr_s, frame_cnt_s;
  logic                ovf_r, ovf_s;
  logic                full_r, afull_r, avail_r, pop_d_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_eod_r, rd_valid_r;
  logic                wr_accept_s, commit_s, drop_s, pop_s, pop_eod_s;
  int unsigned         occ_s;
  logic [ENTRY_W-1:0]  ram_q_s;
  logic [DEPTH-1:0]    eod_vec_r;

  // Write-side control: abort beats write, overflow holds off writes until the frame's EOD
  always_comb begin
    wr_ptr_s    = wr_ptr_r;
    cm_ptr_s    = cm_ptr_r;
    ovf_s       = ovf_r;
    wr_accept_s = 1'b0;
    commit_s    = 1'b0;
    drop_s      = 1'b0;
    if (wr_abort) begin
      wr_ptr_s = cm_ptr_r;
      ovf_s    = 1'b0;
    end else if (wr_en && (ovf_r || full_r)) begin
      if (wr_eod) begin
        wr_ptr_s = cm_ptr_r;
        ovf_s    = 1'b0;
        drop_s   = 1'b1;
      end else begin
        ovf_s = 1'b1;
      end
    end else if (wr_en) begin
      wr_accept_s = 1'b1;
      wr_ptr_s    = wr_ptr_r + PTR_ONE;
      if (wr_eod) begin
        commit_s = 1'b1;
        cm_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        cm_ptr_s = cm_ptr_r;
      end
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
  end

  // Read-side control and frame accounting
  always_comb begin
    pop_s     = rd_en && (rd_ptr_r != cm_ptr_r);
    pop_eod_s = pop_s && eod_vec_r[rd_ptr_r[ADDR_W-1:0]];
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    case ({commit_s, pop_eod_s})
      2'b10:   frame_cnt_s = frame_cnt_r + PTR_ONE;
      2'b01:   frame_cnt_s = frame_cnt_r - PTR_ONE;
      default: frame_cnt_s = frame_cnt_r;
    endcase
    occ_s = ptr_occupancy(32'(wr_ptr_s), 32'(rd_ptr_s), 32'(ADDR_W));
  end

  // Pointer, flag and counter state
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_r    <= PTR_ZERO;
      cm_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      frame_cnt_r <= PTR_ZERO;
      ovf_r       <= 1'b0;
      full_r      <= 1'b0;
      afull_r     <= 1'b0;
      avail_r     <= 1'b0;
      pop_d_r     <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_s;
      cm_ptr_r    <= cm_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      frame_cnt_r <= frame_cnt_s;
      ovf_r       <= ovf_s;
      full_r      <= (occ_s == 32'(DEPTH));
      afull_r     <= (occ_s >= 32'(AFULL_LVL));
      avail_r     <= (frame_cnt_s != PTR_ZERO);
      pop_d_r     <= pop_s;
    end
  end

  // EOD shadow so a pop can retire its frame on the same edge it is honoured
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      eod_vec_r[wr_ptr_r[ADDR_W-1:0]] <= wr_eod;
    end
  end

  // Output stage: presents the RAM word one edge after the read, holding it otherwise
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_eod_r   <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= pop_d_r;
      if (pop_d_r) begin
        rd_data_r <= ram_q_s[DATA_W-1:0];
        rd_eod_r  <= ram_q_s[EOD_BIT];
      end
    end
  end

  frame_store_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data ({wr_eod, wr_data}),
    .rd_en   (pop_s),
    .rd_addr (rd_ptr_r[ADDR_W-1:0]),
    .rd_data (ram_q_s)
  );

`ifdef FRAME_STORE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  // Saturating count of frames lost to overflow
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
    end else if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
  assign drop_cnt      = {DROP_CNT_W{1'b0}};
`endif

  assign full_flag   = full_r;
  assign afull_flag  = afull_r;
  assign rd_data     = rd_data_r;
  assign rd_eod      = rd_eod_r;
  assign rd_valid    = rd_valid_r;
  assign frame_avail = avail_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_frame_store_fifo.sv
// tb_frame_store_fifo: directed self-checking bench for frame_store_fifo (DEPTH=16, AFULL_LVL=12).
module tb_frame_store_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
`ifdef FRAME_STORE_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  logic              clk;
  logic              arst_n;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en, wr_eod, wr_abort;
  logic              full_flag, afull_flag;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_eod, rd_valid, frame_avail;
  logic [ADDR_W:0]   frame_cnt;
  logic [15:0]       drop_cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  frame_store_fifo #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AFULL_LVL (12)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .wr_eod      (wr_eod),
    .wr_abort    (wr_abort),
    .full_flag   (full_flag),
    .afull_flag  (afull_flag),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_eod      (rd_eod),
    .rd_valid    (rd_valid),
    .frame_avail (frame_avail),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic eod);
    wr_en   = 1'b1;
    wr_data = d;
    wr_eod  = eod;
    step();
    wr_en  = 1'b0;
    wr_eod = 1'b0;
  endtask

  // Pops n bytes with rd_en held, checking each byte one cycle after its pop edge
  task automatic pop_check(input string tag, input int n, input logic [7:0] exp_d [8],
                           input logic [7:0] eod_mask);
    rd_en = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) rd_en = 1'b0;
      step();
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, 32'(rd_data), 32'(exp_d[i]));
      check({tag, "_eod"}, 32'(rd_eod), 32'(eod_mask[i]));
    end
  endtask

  initial begin
    arst_n   = 1'b0;
    wr_data  = 8'h00;
    wr_en    = 1'b0;
    wr_eod   = 1'b0;
    wr_abort = 1'b0;
    rd_en    = 1'b0;
    step();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_avail", 32'(frame_avail), 32'd0);
    check("rst_full", 32'(full_flag), 32'd0);
    check("rst_afull", 32'(afull_flag), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    arst_n = 1'b1;
    step();

    // Single 5-byte frame
    for (int i = 1; i <= 4; i++) wr_byte(8'(i), 1'b0);
    check("f1_fcnt_pre", 32'(frame_cnt), 32'd0);
    check("f1_avail_pre", 32'(frame_avail), 32'd0);
    wr_byte(8'h05, 1'b1);
    check("f1_fcnt", 32'(frame_cnt), 32'd1);
    check("f1_avail", 32'(frame_avail), 32'd1);
    pop_check("f1", 5, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00}, 8'b0001_0000);
    check("f1_fcnt_end", 32'(frame_cnt), 32'd0);
    step();
    check("f1_idle_valid", 32'(rd_valid), 32'd0);
    check("f1_hold_data", 32'(rd_data), 32'h05);

    // Partial frame is invisible to the reader, then aborted
    wr_byte(8'h11, 1'b0);
    wr_byte(8'h12, 1'b0);
    wr_byte(8'h13, 1'b0);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("part_valid", 32'(rd_valid), 32'd0);
      check("part_avail", 32'(frame_avail), 32'd0);
    end
    rd_en    = 1'b0;
    wr_abort = 1'b1;
    step();
    wr_abort = 1'b0;
    wr_byte(8'hA0, 1'b0);
    wr_byte(8'hA1, 1'b1);
    check("abort_fcnt", 32'(frame_cnt), 32'd1);
    pop_check("abort", 2, '{8'hA0, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'b0000_0010);

    // 20-byte frame overflows and is dropped whole
    for (int i = 0; i < 20; i++) begin
      wr_byte(8'(32'h40 + i), (i == 19));
      if (i == 10) check("ovf_afull_11", 32'(afull_flag), 32'd0);
      if (i == 11) check("ovf_afull_12", 32'(afull_flag), 32'd1);
      if (i == 14) check("ovf_full_15", 32'(full_flag), 32'd0);
      if (i == 15) check("ovf_full_16", 32'(full_flag), 32'd1);
      if (i == 17) check("ovf_full_hold", 32'(full_flag), 32'd1);
    end
    check("ovf_drop", 32'(drop_cnt), 32'(EXP_DROP));
    check("ovf_fcnt", 32'(frame_cnt), 32'd0);
    check("ovf_full_clr", 32'(full_flag), 32'd0);
    check("ovf_afull_clr", 32'(afull_flag), 32'd0);
    rd_en = 1'b1;
    step();
    step();
    rd_en = 1'b0;
    check("ovf_empty_valid", 32'(rd_valid), 32'd0);

    // Two frames back to back
    wr_byte(8'hB0, 1'b0);
    wr_byte(8'hB1, 1'b1);
    check("two_fcnt1", 32'(frame_cnt), 32'd1);
    wr_byte(8'hC0, 1'b0);
    wr_byte(8'hC1, 1'b0);
    wr_byte(8'hC2, 1'b1);
    check("two_fcnt2", 32'(frame_cnt), 32'd2);
    pop_check("two", 5, '{8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00}, 8'b0001_0010);
    check("two_fcnt_end", 32'(frame_cnt), 32'd0);

    // Commit of frame B on the same edge as frame A's EOD pop
    wr_byte(8'hD0, 1'b0);
    wr_byte(8'hD1, 1'b1);
    wr_byte(8'hE0, 1'b0);
    check("sim_fcnt_pre", 32'(frame_cnt), 32'd1);
    rd_en = 1'b1;
    step();
    wr_byte(8'hE1, 1'b1);
    rd_en = 1'b0;
    check("sim_fcnt", 32'(frame_cnt), 32'd1);
    check("sim_avail", 32'(frame_avail), 32'd1);
    check("sim_d0", 32'(rd_data), 32'hD0);
    step();
    check("sim_d1", 32'(rd_data), 32'hD1);
    check("sim_d1_eod", 32'(rd_eod), 32'd1);
    pop_check("sim_b", 2, '{8'hE0, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'b0000_0010);
    check("sim_fcnt_end", 32'(frame_cnt), 32'd0);

    // Reset in the middle of traffic
    wr_byte(8'h77, 1'b1);
    wr_byte(8'h78, 1'b1);
    wr_byte(8'hF0, 1'b0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    step();
    check("pre_rst_data", 32'(rd_data), 32'h77);
    check("pre_rst_fcnt", 32'(frame_cnt), 32'd1);
    arst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_data", 32'(rd_data), 32'd0);
    check("mid_rst_eod", 32'(rd_eod), 32'd0);
    check("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_avail", 32'(frame_avail), 32'd0);
    step();
    arst_n = 1'b1;
    step();
    rd_en = 1'b1;
    step();
    step();
    rd_en = 1'b0;
    check("post_rst_empty", 32'(rd_valid), 32'd0);
    wr_byte(8'h5A, 1'b0);
    wr_byte(8'h5B, 1'b1);
    check("post_rst_fcnt", 32'(frame_cnt), 32'd1);
    pop_check("post_rst", 2, '{8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'b0000_0010);
    check("post_rst_fcnt_end", 32'(frame_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
